// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_pkg                                                |
// | Description : Shared widths and status-flag bit positions for the    |
// |               ALU writeback slice.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package alu_pkg;

  // Default ALU result width and register-index width
  localparam int DATA_W_DEFAULT = 64;
  localparam int ADDR_W_DEFAULT = 5;

  // Bit positions inside the {V,C,N,Z} status word
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/wb_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : wb_fifo2                                               |
// | Description : Two-entry in-order FIFO. Slot 0 is always the head, so |
// |               the output is a plain register with no read mux.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module wb_fifo2 #(
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem0;
  logic [WIDTH-1:0] r_mem1;
  logic [1:0]       r_count;
  logic             w_pop;
  logic             w_push;

  // Guard the handshakes so the count can never wrap in either direction
  always_comb begin
    w_pop  = pop && (r_count != 2'd0);
    w_push = push && ((r_count != 2'd2) || w_pop);
  end

  // Shift-style storage: pops move slot 1 into the head slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem0  <= '0;
      r_mem1  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= din;
          else                 r_mem1 <= din;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem0 <= din;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_mem0;
  assign count = r_count;

endmodule : wb_fifo2
`default_nettype wire

// File: rtl/alu_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_writeback                                          |
// | Description : Queues ALU results for the register-file write port    |
// |               and maintains the architectural {V,C,N,Z} flags.       |
// |               Writes to x0 are dropped; their flags still apply.     |
// | Config      : ALU_WRITEBACK_STICKY_V_EN - when defined, V is sticky  |
// |               and cleared only by flags_clr.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_status,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic              in_set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_dest,
  output logic [3:0]        flags,
  input  logic              flags_clr,
  output logic [1:0]        occupancy
);

  localparam int ENTRY_W = DATA_W + ADDR_W;

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic               w_flag_upd;
  logic [ENTRY_W-1:0] w_head;
  logic [1:0]         w_count;
  logic [3:0]         r_flags;

  // Handshakes derive only from FIFO count, never from in_* data paths
  always_comb begin
    in_ready   = (w_count != 2'd2);
    out_valid  = (w_count != 2'd0);
    w_accept   = in_valid && in_ready;
    w_push     = w_accept && (in_dest != '0);
    w_pop      = out_valid && out_ready;
    w_flag_upd = w_accept && in_set_flags;
  end

  wb_fifo2 #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (w_push),
    .din   ({in_data, in_dest}),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count)
  );

  assign out_data  = w_head[ENTRY_W-1:ADDR_W];
  assign out_dest  = w_head[ADDR_W-1:0];
  assign occupancy = w_count;
  assign flags     = r_flags;

`ifdef ALU_WRITEBACK_STICKY_V_EN
  // V accumulates overflow until software clears it; a same-cycle update wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_upd) begin
      r_flags[FLAG_V]        <= (r_flags[FLAG_V] & ~flags_clr) | in_status[FLAG_V];
      r_flags[FLAG_C:FLAG_Z] <= in_status[FLAG_C:FLAG_Z];
    end else if (flags_clr) begin
      r_flags[FLAG_V] <= 1'b0;
    end
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = flags_clr;

  // All four flags load together on an accepted flag-setting result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_flag_upd) begin
      r_flags <= in_status;
    end
  end
`endif

endmodule : alu_writeback
`default_nettype wire

// File: tb/tb_alu_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_writeback                                       |
// | Description : Self-checking bench for alu_writeback: table-driven    |
// |               vectors plus directed back-pressure, sticky-V and      |
// |               mid-operation reset sequences, with a write scoreboard.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_writeback;

  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk          = 1'b0;
  logic          reset        = 1'b1;
  logic          in_valid     = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data      = '0;
  logic [3:0]    in_status    = 4'b0000;
  logic [AW-1:0] in_dest      = '0;
  logic          in_set_flags = 1'b0;
  logic          out_valid;
  logic          out_ready    = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_dest;
  logic [3:0]    flags;
  logic          flags_clr    = 1'b0;
  logic [1:0]    occupancy;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    status;
    logic [AW-1:0] dest;
    logic          sf;
    logic [3:0]    exp_flags;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] dest;
  } wr_t;

  vec_t vecs[9];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   writes = 0;
  int   wbase;

  alu_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_status    (in_status),
    .in_dest      (in_dest),
    .in_set_flags (in_set_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dest     (out_dest),
    .flags        (flags),
    .flags_clr    (flags_clr),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [3:0] st,
                       input logic [AW-1:0] dst, input logic sf);
    in_valid     = 1'b1;
    in_data      = d;
    in_status    = st;
    in_dest      = dst;
    in_set_flags = sf;
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input logic [AW-1:0] dst);
    wr_t e;
    e.data = d;
    e.dest = dst;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every granted write must match the oldest expected entry
  always @(negedge clk) begin
    wr_t e;
    if (!reset && out_valid && out_ready) begin
      writes++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h dest %0d expected no write", out_data, out_dest);
      end else begin
        e = sb.pop_front();
        chk("wr_data", out_data, e.data);
        chk("wr_dest", {59'b0, out_dest}, {59'b0, e.dest});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{64'd4,                  4'b0000, 5'd3,  1'b1, 4'b0000};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFE, 4'b0010, 5'd7,  1'b1, 4'b0010};
    vecs[2] = '{64'd123,                4'b0101, 5'd9,  1'b0, 4'b0010};
    vecs[3] = '{64'd5,                  4'b0001, 5'd0,  1'b1, 4'b0001};
    vecs[4] = '{64'hAAAA,               4'b0100, 5'd31, 1'b1, 4'b0100};
    vecs[5] = '{64'd77,                 4'b1000, 5'd4,  1'b1, 4'b1000};
    vecs[6] = '{64'd8,                  4'b1001, 5'd5,  1'b1, 4'b1001};
    vecs[7] = '{64'd9,                  4'b0110, 5'd0,  1'b0, 4'b1001};
    vecs[8] = '{64'd10,                 4'b1110, 5'd2,  1'b1, 4'b1110};

    // Reset state
    #12;
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data",  out_data, 64'd0);
    chk("rst_out_dest",  out_dest, 5'd0);
    chk("rst_flags",     flags, 4'b0000);
    chk("rst_in_ready",  in_ready, 1'b1);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;

    // Table vectors, one accept per cycle with the write port always granted
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].data, vecs[i].status, vecs[i].dest, vecs[i].sf);
      if (vecs[i].dest != '0) push_exp(vecs[i].data, vecs[i].dest);
      step();
      chk($sformatf("vec%0d_flags", i), flags, vecs[i].exp_flags);
      chk($sformatf("vec%0d_occupancy", i), occupancy, (vecs[i].dest != '0) ? 2'd1 : 2'd0);
      chk($sformatf("vec%0d_out_valid", i), out_valid, (vecs[i].dest != '0) ? 1'b1 : 1'b0);
    end
    in_valid = 1'b0;
    step();
    chk("drain_occupancy", occupancy, 2'd0);

    // Back-pressure: fill both slots, third result must be ignored
    out_ready = 1'b0;
    wbase     = writes;
    drive(64'd1, 4'b0000, 5'd1, 1'b0);
    push_exp(64'd1, 5'd1);
    step();
    chk("bp1_in_ready", in_ready, 1'b1);
    chk("bp1_occupancy", occupancy, 2'd1);
    drive(64'd2, 4'b0000, 5'd2, 1'b0);
    push_exp(64'd2, 5'd2);
    step();
    chk("bp2_in_ready", in_ready, 1'b0);
    chk("bp2_occupancy", occupancy, 2'd2);
    chk("bp2_head_data", out_data, 64'd1);
    drive(64'd3, 4'b1111, 5'd3, 1'b1);
    step();
    chk("bp3_occupancy", occupancy, 2'd2);
    chk("bp3_flags_hold", flags, 4'b1110);
    chk("bp3_head_data", out_data, 64'd1);
    chk("bp3_head_dest", out_dest, 5'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    chk("bp_drain_occupancy", occupancy, 2'd0);
    chk("bp_write_count", writes - wbase, 2);

    // Overflow flag behaviour and flags_clr
    drive(64'd11, 4'b1000, 5'd6, 1'b1);
    push_exp(64'd11, 5'd6);
    step();
    chk("v_set_flags", flags, 4'b1000);
    drive(64'd12, 4'b0000, 5'd6, 1'b1);
    push_exp(64'd12, 5'd6);
    step();
`ifdef ALU_WRITEBACK_STICKY_V_EN
    chk("v_second_flags", flags, 4'b1000);
`else
    chk("v_second_flags", flags, 4'b0000);
`endif
    in_valid  = 1'b0;
    flags_clr = 1'b1;
    step();
    chk("v_clr_flags", flags, 4'b0000);
    drive(64'd13, 4'b1000, 5'd0, 1'b1);
    step();
    chk("v_clr_with_update", flags, 4'b1000);
    flags_clr = 1'b0;
    in_valid  = 1'b0;
    step();

    // Reset with a full queue discards both entries without writing them
    out_ready = 1'b0;
    drive(64'd21, 4'b0111, 5'd1, 1'b1);
    push_exp(64'd21, 5'd1);
    step();
    drive(64'd22, 4'b0111, 5'd2, 1'b1);
    push_exp(64'd22, 5'd2);
    step();
    chk("pre_rst_occupancy", occupancy, 2'd2);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_occupancy", occupancy, 2'd0);
    chk("mid_rst_flags", flags, 4'b0000);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    sb.delete();
    wbase     = writes;
    out_ready = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    chk("post_rst_writes", writes - wbase, 0);
    chk("post_rst_occupancy", occupancy, 2'd0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_writeback
`default_nettype wire
